// File: rtl/sdram_pll_seq_pkg.sv
// Shared types and sizing helpers for the SDRAM-domain PLL sequencer.
package sdram_pll_seq_pkg;

  // Sequencer states; the encodings are visible on the state output.
  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } seq_state_t;

  // Lock-loss event counter width and the value it sticks at.
  localparam int                LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_SAT = '1;

  // Width of the shared cycle counter: wide enough for the largest terminal count, plus one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  // NOTE: sequential state uses non-blocking assignments so both flops sample the old value at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_sequencer.sv
// Sequences the SDRAM-domain PLL: reset pulse, lock wait with timeout and retries,
// lock debounce, and domain reset release; re-locks on lock loss or on request.
module sdram_pll_sequencer
  import sdram_pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              domain_rst_n,
  output logic              fail,
  output logic [2:0]        state,
  output logic [1:0]        attempt_cnt,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] RST_HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAST_ATTEMPT  = 2'(MAX_RETRIES);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        att_q, att_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lock_s;

  // pll_locked comes from another clock domain; lock_s is the only lock view used below.
  sync_2ff u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state, counter, attempt and loss-count logic; relock_req overrides every transition.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    loss_d  = loss_q;

    if (relock_req) begin
      state_d = ST_RESET_HOLD;
      cnt_d   = '0;
      att_d   = '0;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          if (cnt_q == RST_HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (att_q == LAST_ATTEMPT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET_HOLD;
              att_d   = att_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        // A lock drop here restarts both the debounce and the lock timeout, but is not a new attempt.
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            att_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
            if (loss_q != LOSS_SAT) loss_d = loss_q + LOSS_W'(1);
          end
        end

        ST_FAIL: begin
          // Parked until relock_req or reset_n.
        end

        default: begin
          state_d = ST_RESET_HOLD;
          cnt_d   = '0;
          att_d   = '0;
        end
      endcase
    end
  end

  // State registers plus outputs decoded from next state, so outputs change on the transition edge.
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q      <= ST_RESET_HOLD;
      cnt_q        <= '0;
      att_q        <= '0;
      loss_q       <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      att_q        <= att_d;
      loss_q       <= loss_d;
      pll_rst      <= (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
      domain_rst_n <= (state_d == ST_RUN);
      fail         <= (state_d == ST_FAIL);
    end
  end

  assign state       = state_q;
  assign attempt_cnt = att_q;
  assign loss_cnt    = loss_q;

endmodule
